// File: rtl/admm_pkg.sv
// Shared constants, FSM state type and saturation bounds for the ADMM dual-update stage.
// Saturation bounds are consumed only when ADMM_DUAL_SAT_EN is defined.
package admm_pkg;

  localparam int W_DEF           = 16;
  localparam int STATE_DIM_DEF   = 12;
  localparam int CONTROL_DIM_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/admm_dual_update_lane.sv
// Single dual lane: r = a + b - c on W-bit two's-complement operands.
// ADMM_DUAL_SAT_EN defined: clamp to the W-bit signed range; otherwise wrap modulo 2^W.
module dual_lane
  import admm_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] r
);

`ifdef ADMM_DUAL_SAT_EN
  localparam logic signed [W+1:0] MAX_S = (W+2)'(sat_max(W));
  localparam logic signed [W+1:0] MIN_S = (W+2)'(sat_min(W));

  logic signed [W+1:0] sum_s;

  // Exact sum in W+2 bits, then clamp to the W-bit signed range
  always_comb begin
    sum_s = {{2{a[W-1]}}, a} + {{2{b[W-1]}}, b} - {{2{c[W-1]}}, c};
    if (sum_s > MAX_S) begin
      r = MAX_S[W-1:0];
    end else if (sum_s < MIN_S) begin
      r = MIN_S[W-1:0];
    end else begin
      r = sum_s[W-1:0];
    end
  end
`else
  // Low W bits of the exact sum do not depend on the extension bits
  always_comb begin
    r = a + b - c;
  end
`endif

endmodule

// File: rtl/admm_dual_update.sv
// ADMM dual update: y_out = y_k + u_k - z_k, g_out = g_k + x_k - v_k on a snapshot taken at start.
// Overflow handling selected by macro ADMM_DUAL_SAT_EN (defined: saturate, undefined: wrap).
module admm_dual_update
  import admm_pkg::*;
#(
  parameter int STATE_DIM   = STATE_DIM_DEF,
  parameter int CONTROL_DIM = CONTROL_DIM_DEF,
  parameter int W           = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] u_k   [CONTROL_DIM],
  input  logic [W-1:0] z_k   [CONTROL_DIM],
  input  logic [W-1:0] y_k   [CONTROL_DIM],
  input  logic [W-1:0] x_k   [STATE_DIM],
  input  logic [W-1:0] v_k   [STATE_DIM],
  input  logic [W-1:0] g_k   [STATE_DIM],
  output logic [W-1:0] y_out [CONTROL_DIM],
  output logic [W-1:0] g_out [STATE_DIM],
  output logic         done
);

  fsm_state_e state_r;
  fsm_state_e state_next_s;
  logic       capture_en_s;
  logic       calc_en_s;
  logic       done_next_s;
  logic       done_r;

  logic [W-1:0] u_r [CONTROL_DIM];
  logic [W-1:0] z_r [CONTROL_DIM];
  logic [W-1:0] y_r [CONTROL_DIM];
  logic [W-1:0] x_r [STATE_DIM];
  logic [W-1:0] v_r [STATE_DIM];
  logic [W-1:0] g_r [STATE_DIM];

  logic [W-1:0] y_new_s   [CONTROL_DIM];
  logic [W-1:0] g_new_s   [STATE_DIM];
  logic [W-1:0] y_out_r   [CONTROL_DIM];
  logic [W-1:0] g_out_r   [STATE_DIM];

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; start only matters in IDLE
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC:    state_next_s = DONE;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM-derived enables
  always_comb begin
    capture_en_s = (state_r == IDLE) && start;
    calc_en_s    = (state_r == CALC);
    done_next_s  = (state_next_s == DONE);
  end

  for (genvar i = 0; i < CONTROL_DIM; i++) begin : g_y_lane
    dual_lane #(.W(W)) u_lane (
      .a (y_r[i]),
      .b (u_r[i]),
      .c (z_r[i]),
      .r (y_new_s[i])
    );
  end

  for (genvar i = 0; i < STATE_DIM; i++) begin : g_g_lane
    dual_lane #(.W(W)) u_lane (
      .a (g_r[i]),
      .b (x_r[i]),
      .c (v_r[i]),
      .r (g_new_s[i])
    );
  end

  // Input snapshot, result registers and done pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      done_r <= 1'b0;
      for (int i = 0; i < CONTROL_DIM; i++) begin
        u_r[i]     <= {W{1'b0}};
        z_r[i]     <= {W{1'b0}};
        y_r[i]     <= {W{1'b0}};
        y_out_r[i] <= {W{1'b0}};
      end
      for (int i = 0; i < STATE_DIM; i++) begin
        x_r[i]     <= {W{1'b0}};
        v_r[i]     <= {W{1'b0}};
        g_r[i]     <= {W{1'b0}};
        g_out_r[i] <= {W{1'b0}};
      end
    end else begin
      done_r <= done_next_s;
      if (capture_en_s) begin
        for (int i = 0; i < CONTROL_DIM; i++) begin
          u_r[i] <= u_k[i];
          z_r[i] <= z_k[i];
          y_r[i] <= y_k[i];
        end
        for (int i = 0; i < STATE_DIM; i++) begin
          x_r[i] <= x_k[i];
          v_r[i] <= v_k[i];
          g_r[i] <= g_k[i];
        end
      end
      if (calc_en_s) begin
        for (int i = 0; i < CONTROL_DIM; i++) begin
          y_out_r[i] <= y_new_s[i];
        end
        for (int i = 0; i < STATE_DIM; i++) begin
          g_out_r[i] <= g_new_s[i];
        end
      end
    end
  end

  assign y_out = y_out_r;
  assign g_out = g_out_r;
  assign done  = done_r;

endmodule

// File: tb/tb_admm_dual_update.sv
// Table-driven bench for admm_dual_update plus directed handshake, reset and back-to-back sequences.
// Overflow expectations follow ADMM_DUAL_SAT_EN.
module tb_admm_dual_update;

  typedef struct {
    logic [3:0][15:0]  u, z, y, ey;
    logic [11:0][15:0] x, v, g, eg;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] u_k [4];
  logic [15:0] z_k [4];
  logic [15:0] y_k [4];
  logic [15:0] x_k [12];
  logic [15:0] v_k [12];
  logic [15:0] g_k [12];
  logic [15:0] y_out [4];
  logic [15:0] g_out [12];
  logic        done;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl [4];
  vec_t zero_v;

  admm_dual_update dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .u_k   (u_k),
    .z_k   (z_k),
    .y_k   (y_k),
    .x_k   (x_k),
    .v_k   (v_k),
    .g_k   (g_k),
    .y_out (y_out),
    .g_out (g_out),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_upd(logic [15:0] a, logic [15:0] b, logic [15:0] c);
    int s;
    s = int'($signed(a)) + int'($signed(b)) - int'($signed(c));
`ifdef ADMM_DUAL_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int idx, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, $signed(act), $signed(exp));
    end
  endtask

  task automatic apply(vec_t t);
    for (int i = 0; i < 4; i++) begin
      u_k[i] = t.u[i]; z_k[i] = t.z[i]; y_k[i] = t.y[i];
    end
    for (int i = 0; i < 12; i++) begin
      x_k[i] = t.x[i]; v_k[i] = t.v[i]; g_k[i] = t.g[i];
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < 4; i++) begin
      u_k[i] = 16'h5A5A; z_k[i] = 16'h1234; y_k[i] = 16'h7777;
    end
    for (int i = 0; i < 12; i++) begin
      x_k[i] = 16'hA5A5; v_k[i] = 16'h0F0F; g_k[i] = 16'h3333;
    end
  endtask

  task automatic check_all(string tag, vec_t t, logic exp_done);
    chk({tag, ".done"}, 0, {15'd0, done}, {15'd0, exp_done});
    for (int i = 0; i < 4; i++)  chk({tag, ".y_out"}, i, y_out[i], t.ey[i]);
    for (int i = 0; i < 12; i++) chk({tag, ".g_out"}, i, g_out[i], t.eg[i]);
  endtask

  task automatic run_vec(int n);
    apply(tbl[n]);
    start = 1'b1;
    step();
    start = 1'b0;
    scramble();
    chk($sformatf("v%0d.calc_done", n), 0, {15'd0, done}, 16'd0);
    step();
    check_all($sformatf("v%0d.result", n), tbl[n], 1'b1);
    step();
    check_all($sformatf("v%0d.hold", n), tbl[n], 1'b0);
  endtask

  initial begin
    zero_v = '{default: '0};
    for (int k = 0; k < 4; k++) tbl[k] = zero_v;

    // basic: y_out=[-3,-1,1,3], g_out[i]=2i-11
    for (int i = 0; i < 4; i++) begin
      tbl[0].u[i] = 16'(i + 1); tbl[0].z[i] = 16'(4 - i); tbl[0].ey[i] = 16'(2 * i - 3);
    end
    for (int i = 0; i < 12; i++) begin
      tbl[0].x[i] = 16'(i + 1); tbl[0].v[i] = 16'(12 - i); tbl[0].eg[i] = 16'(2 * i - 11);
    end
    // accumulate: previous duals fed back, results doubled
    tbl[1] = tbl[0];
    tbl[1].y = tbl[0].ey;
    tbl[1].g = tbl[0].eg;
    for (int i = 0; i < 4; i++)  tbl[1].ey[i] = 16'(4 * i - 6);
    for (int i = 0; i < 12; i++) tbl[1].eg[i] = 16'(4 * i - 22);
    // overflow corners, lanes 0..3 of both vectors
    tbl[2].y[0] = 16'h7FFF; tbl[2].u[0] = 16'd1;    tbl[2].z[0] = 16'd0;
    tbl[2].y[1] = 16'h8000; tbl[2].u[1] = 16'd0;    tbl[2].z[1] = 16'd1;
    tbl[2].y[2] = 16'h7FFF; tbl[2].u[2] = 16'h7FFF; tbl[2].z[2] = 16'h8000;
    tbl[2].y[3] = 16'h8000; tbl[2].u[3] = 16'h8000; tbl[2].z[3] = 16'h7FFF;
    for (int i = 0; i < 4; i++) begin
      tbl[2].g[i] = tbl[2].y[i]; tbl[2].x[i] = tbl[2].u[i]; tbl[2].v[i] = tbl[2].z[i];
    end
`ifdef ADMM_DUAL_SAT_EN
    tbl[2].ey[0] = 16'h7FFF; tbl[2].ey[1] = 16'h8000; tbl[2].ey[2] = 16'h7FFF; tbl[2].ey[3] = 16'h8000;
`else
    tbl[2].ey[0] = 16'h8000; tbl[2].ey[1] = 16'h7FFF; tbl[2].ey[2] = 16'h7FFE; tbl[2].ey[3] = 16'h8001;
`endif
    for (int i = 0; i < 4; i++) tbl[2].eg[i] = tbl[2].ey[i];
    for (int i = 4; i < 12; i++) begin
      tbl[2].g[i] = 16'd100; tbl[2].x[i] = 16'hFFCE; tbl[2].v[i] = 16'd25; tbl[2].eg[i] = 16'd25;
    end
    // random operands, expectation from the reference model
    for (int i = 0; i < 4; i++) begin
      tbl[3].u[i] = 16'($urandom); tbl[3].z[i] = 16'($urandom); tbl[3].y[i] = 16'($urandom);
      tbl[3].ey[i] = ref_upd(tbl[3].y[i], tbl[3].u[i], tbl[3].z[i]);
    end
    for (int i = 0; i < 12; i++) begin
      tbl[3].x[i] = 16'($urandom); tbl[3].v[i] = 16'($urandom); tbl[3].g[i] = 16'($urandom);
      tbl[3].eg[i] = ref_upd(tbl[3].g[i], tbl[3].x[i], tbl[3].v[i]);
    end

    reset = 1'b0;
    start = 1'b1;
    scramble();
    step();
    step();
    check_all("reset", zero_v, 1'b0);
    reset = 1'b1;
    start = 1'b0;
    step();

    for (int n = 0; n < 4; n++) run_vec(n);

    // start held through CALC and DONE is ignored
    apply(tbl[0]);
    start = 1'b1;
    step();
    apply(tbl[1]);
    step();
    check_all("ign.result", tbl[0], 1'b1);
    step();
    start = 1'b0;
    chk("ign.idle_done", 0, {15'd0, done}, 16'd0);
    step();
    check_all("ign.hold", tbl[0], 1'b0);

    // reset during CALC aborts with cleared outputs and no done
    apply(tbl[1]);
    start = 1'b1;
    step();
    start = 1'b0;
    reset = 1'b0;
    step();
    check_all("rst_mid", zero_v, 1'b0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_all("rst_after", zero_v, 1'b0);
    end

    // start held high: capture every 3rd edge, done one edge later
    for (int c = 0; c < 9; c++) begin
      for (int i = 0; i < 4; i++) begin
        u_k[i] = 16'(c + 10); z_k[i] = 16'd0; y_k[i] = 16'd0;
      end
      for (int i = 0; i < 12; i++) begin
        x_k[i] = 16'(c + 10); v_k[i] = 16'd0; g_k[i] = 16'd0;
      end
      start = 1'b1;
      step();
      chk("b2b.done", c, {15'd0, done}, (c % 3 == 1) ? 16'd1 : 16'd0);
      if (c % 3 == 1) begin
        chk("b2b.y_out0", c, y_out[0], 16'(c + 9));
        chk("b2b.g_out11", c, g_out[11], 16'(c + 9));
      end
    end
    start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
